// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - SUBLEQ control FSM: operand fetch, load, write-back and branch
// Owns the pc and the memory request/ack handshake; one instruction = six memory transactions.
module subleq_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clkIn,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stopReq,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memRdata,
    input  logic                  memAck,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  instrDone
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        FETCH_C = 3'd3,
        LOAD_A  = 3'd4,
        LOAD_B  = 3'd5,
        WRITE_B = 3'd6,
        HALTED  = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] opa_q, opa_d;
    logic [ADDR_WIDTH-1:0] opb_q, opb_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;
    logic [DATA_WIDTH-1:0] vala_q, vala_d;
    logic [DATA_WIDTH-1:0] valb_q, valb_d;
    logic                  instr_done_q, instr_done_d;

    logic [DATA_WIDTH-1:0] diff;
    logic                  leq;

    assign diff = valb_q - vala_q;
    assign leq  = diff[DATA_WIDTH-1] | (diff == '0);

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            vala_q       <= '0;
            valb_q       <= '0;
            instr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            vala_q       <= vala_d;
            valb_q       <= valb_d;
            instr_done_q <= instr_done_d;
        end
    end

    // Request outputs decode from registered state only, so they hold steady until the ack.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        vala_d       = vala_q;
        valb_d       = valb_q;
        instr_done_d = 1'b0;
        memReq       = 1'b0;
        memWe        = 1'b0;
        memAddr      = '0;
        memWdata     = '0;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = FETCH_A;
                end
            end
            FETCH_A: begin
                memReq  = 1'b1;
                memAddr = pc_q;
                if (memAck) begin
                    opa_d   = memRdata[ADDR_WIDTH-1:0];
                    state_d = FETCH_B;
                end
            end
            FETCH_B: begin
                memReq  = 1'b1;
                memAddr = pc_q + ADDR_WIDTH'(1);
                if (memAck) begin
                    opb_d   = memRdata[ADDR_WIDTH-1:0];
                    state_d = FETCH_C;
                end
            end
            FETCH_C: begin
                memReq  = 1'b1;
                memAddr = pc_q + ADDR_WIDTH'(2);
                if (memAck) begin
                    opc_d   = memRdata[ADDR_WIDTH-1:0];
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                memReq  = 1'b1;
                memAddr = opa_q;
                if (memAck) begin
                    vala_d  = memRdata;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                memReq  = 1'b1;
                memAddr = opb_q;
                if (memAck) begin
                    valb_d  = memRdata;
                    state_d = WRITE_B;
                end
            end
            WRITE_B: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = opb_q;
                memWdata = diff;
                if (memAck) begin
                    instr_done_d = 1'b1;
                    pc_d         = leq ? opc_q : pc_q + ADDR_WIDTH'(3);
                    // Halt wins over a pending stop so the halted status is never lost.
                    if (leq && (opc_q == HALT_ADDR)) begin
                        state_d = HALTED;
                    end else if (stopReq) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH_A;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc        = pc_q;
    assign busy      = (state_q != IDLE) && (state_q != HALTED);
    assign halted    = (state_q == HALTED);
    assign instrDone = instr_done_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb/tb_subleq_sequencer.sv - directed self-checking bench for subleq_sequencer
module tb_subleq_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start1, stop1, req1, we1, ack1, busy1, halted1, done1;
    logic [7:0] addr1, wdata1, rdata1, pc1;
    logic       start2, stop2, req2, we2, ack2, busy2, halted2, done2;
    logic [7:0] addr2, wdata2, rdata2, pc2;

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [8:0] log1 [$];
    logic [8:0] log2 [$];
    int         wait_n;
    int         wcnt1;
    int         checks;
    int         failures;

    subleq_sequencer dut (
        .clkIn(clk), .reset(rst), .start(start1), .stopReq(stop1),
        .memReq(req1), .memWe(we1), .memAddr(addr1), .memWdata(wdata1),
        .memRdata(rdata1), .memAck(ack1), .pc(pc1), .busy(busy1),
        .halted(halted1), .instrDone(done1)
    );

    subleq_sequencer #(.RESET_PC(8'hFD)) dut2 (
        .clkIn(clk), .reset(rst), .start(start2), .stopReq(stop2),
        .memReq(req2), .memWe(we2), .memAddr(addr2), .memWdata(wdata2),
        .memRdata(rdata2), .memAck(ack2), .pc(pc2), .busy(busy2),
        .halted(halted2), .instrDone(done2)
    );

    assign ack1   = req1 && (wcnt1 >= wait_n);
    assign rdata1 = mem1[addr1];
    assign ack2   = req2;
    assign rdata2 = mem2[addr2];

    always @(posedge clk) begin
        if (req1 && !ack1) wcnt1 <= wcnt1 + 1;
        else               wcnt1 <= 0;
    end

    always @(posedge clk) begin
        if (req1 && ack1) begin
            log1.push_back({we1, addr1});
            if (we1) mem1[addr1] = wdata1;
        end
        if (req2 && ack2) begin
            log2.push_back({we2, addr2});
            if (we2) mem2[addr2] = wdata2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [7:0] a, b, c, va, vb);
        mem1[0] = a; mem1[1] = b; mem1[2] = c;
        mem1[a] = va; mem1[b] = vb;
        log1.delete();
    endtask

    // Starts one instruction, returns cycles from first request to instrDone.
    task automatic run1(input logic chk_stable, output int cyc);
        logic       p_pend;
        logic [7:0] p_addr, p_wdata;
        logic       p_we;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 400) begin
            p_pend = req1 && !ack1; p_addr = addr1; p_we = we1; p_wdata = wdata1;
            tick();
            cyc++;
            if (chk_stable && p_pend) begin
                check("stable_addr", addr1, p_addr);
                check("stable_we", 32'(we1), 32'(p_we));
                check("stable_wdata", wdata1, p_wdata);
            end
        end
        if (cyc >= 400) check("instr_timeout", 32'(done1), 32'd1);
    endtask

    task automatic check_log1(input logic [7:0] a, b);
        logic [8:0] exp [6];
        exp = '{9'h000, 9'h001, 9'h002, {1'b0, a}, {1'b0, b}, {1'b1, b}};
        check("log_len", log1.size(), 32'd6);
        for (int i = 0; i < 6 && i < log1.size(); i++) check("log_req", log1[i], exp[i]);
    endtask

    int cyc;
    int n;

    initial begin
        checks = 0; failures = 0; wait_n = 0;
        start1 = 0; stop1 = 1; start2 = 0; stop2 = 1;
        rst = 1'b1;
        #1;
        check("rst_memReq", 32'(req1), 32'd0);
        check("rst_memAddr", addr1, 32'd0);
        check("rst_memWdata", wdata1, 32'd0);
        check("rst_pc", pc1, 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_halted", 32'(halted1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pc2", pc2, 32'h00FD);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Not taken: 7-5=2
        load_prog(8, 9, 3, 5, 7);
        run1(1'b0, cyc);
        check("nt_cycles", cyc, 32'd6);
        check_log1(8, 9);
        check("nt_mem9", mem1[9], 32'h02);
        check("nt_pc", pc1, 32'h03);
        check("nt_busy", 32'(busy1), 32'd0);
        check("nt_halted", 32'(halted1), 32'd0);
        tick();
        check("nt_done_pulse", 32'(done1), 32'd0);

        // Taken on zero and on negative, C=3
        load_prog(8, 9, 3, 5, 5);
        run1(1'b0, cyc);
        check("tz_mem9", mem1[9], 32'h00);
        check("tz_pc", pc1, 32'h03);
        load_prog(8, 9, 3, 5, 4);
        run1(1'b0, cyc);
        check("tn_mem9", mem1[9], 32'hFF);
        check("tn_pc", pc1, 32'h03);

        // Taken with C=20, then not-taken with C=20
        load_prog(8, 9, 20, 5, 4);
        run1(1'b0, cyc);
        check("t20_mem9", mem1[9], 32'hFF);
        check("t20_pc", pc1, 32'd20);
        load_prog(8, 9, 20, 5, 5);
        run1(1'b0, cyc);
        check("t20z_pc", pc1, 32'd20);
        load_prog(8, 9, 20, 5, 7);
        run1(1'b0, cyc);
        check("nt20_pc", pc1, 32'd3);

        // A=B: diff=0, always taken
        load_prog(8, 8, 30, 6, 6);
        run1(1'b0, cyc);
        check("aeqb_mem8", mem1[8], 32'h00);
        check("aeqb_pc", pc1, 32'd30);

        // Halt: stopReq low, branch to FF
        stop1 = 1'b0;
        load_prog(8, 9, 8'hFF, 1, 1);
        run1(1'b0, cyc);
        check("h_halted", 32'(halted1), 32'd1);
        check("h_busy", 32'(busy1), 32'd0);
        check("h_pc", pc1, 32'hFF);
        check("h_memReq", 32'(req1), 32'd0);
        check("h_mem9", mem1[9], 32'h00);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("h_restart_pc", pc1, 32'h00);
        check("h_restart_busy", 32'(busy1), 32'd1);
        check("h_restart_halted", 32'(halted1), 32'd0);
        n = 0;
        while (!halted1 && n < 100) begin tick(); n++; end
        check("h_rehalt", 32'(halted1), 32'd1);
        check("h_rehalt_mem9", mem1[9], 32'hFF);
        stop1 = 1'b1;

        // Wait states: 3 extra cycles per request
        wait_n = 3;
        load_prog(8, 9, 3, 5, 7);
        run1(1'b1, cyc);
        check("ws_cycles", cyc, 32'd24);
        check_log1(8, 9);
        check("ws_mem9", mem1[9], 32'h02);
        check("ws_pc", pc1, 32'h03);

        // pc wrap on the second instance
        mem2[8'hFD] = 8; mem2[8'hFE] = 9; mem2[8'hFF] = 3;
        mem2[8] = 5; mem2[9] = 7;
        log2.delete();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 50) begin tick(); n++; end
        check("wr_cycles", n, 32'd6);
        check("wr_log_len", log2.size(), 32'd6);
        if (log2.size() == 6) begin
            check("wr_fetch_a", log2[0], 32'h0FD);
            check("wr_fetch_b", log2[1], 32'h0FE);
            check("wr_fetch_c", log2[2], 32'h0FF);
            check("wr_write", log2[5], 32'h109);
        end
        check("wr_pc", pc2, 32'h00);
        check("wr_mem9", mem2[9], 32'h02);
        check("wr_busy", 32'(busy2), 32'd0);
        check("wr_halted", 32'(halted2), 32'd0);

        // Async reset during LOAD_A with ack outstanding
        load_prog(8, 9, 3, 5, 7);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!(req1 && !we1 && addr1 == 8'd8) && n < 60) begin tick(); n++; end
        check("ra_reached", 32'(req1 && !ack1 && addr1 == 8'd8), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ra_memReq", 32'(req1), 32'd0);
        check("ra_memAddr", addr1, 32'd0);
        check("ra_busy", 32'(busy1), 32'd0);
        check("ra_halted", 32'(halted1), 32'd0);
        check("ra_pc", pc1, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("ra_idle_after", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
